// File: rtl/pipe_pkg.sv
// Shared pipeline types: EXE->MEM / MEM->WB payloads, forwarding bus, load-op encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Field order in every struct matches the payload bit order on the pipeline buses.
package pipe_pkg;

  localparam int EXE2MEM_W = 71;
  localparam int MEM2WB_W  = 70;
  localparam int MEM_FWD_W = 38;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_H  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4
  } ld_op_e;

  // {pc, res_from_mem, rf_we, rf_waddr, alu_result}
  typedef struct packed {
    logic [31:0] pc;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
  } exe2mem_t;

  // {pc, rf_we, rf_waddr, final_result}
  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] final_result;
  } mem2wb_t;

  // {fwd_we, rf_waddr, final_result}
  typedef struct packed {
    logic        fwd_we;
    logic [4:0]  rf_waddr;
    logic [31:0] final_result;
  } mem_fwd_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the EXE->MEM->WB handshake, SRAM read data and forwarding bus around mem_stage.
// Latency: n/a (wires only).
// Backpressure: WB_allowin from WB, MEM_allowin toward EXE.
// master = upstream/environment side (drives EXE payload, SRAM data, WB_allowin);
// slave  = mem_stage side. EXE_to_MEM_ld_op exists only when MEM_SUBWORD_LD_EN is defined.
interface mem_stage_if;
  import pipe_pkg::*;

  logic                 EXE_to_MEM_valid;
  logic [EXE2MEM_W-1:0] MEM_signal;
`ifdef MEM_SUBWORD_LD_EN
  logic [2:0]           EXE_to_MEM_ld_op;
`endif
  logic [31:0]          data_sram_rdata;
  logic                 WB_allowin;
  logic                 MEM_allowin;
  logic                 MEM_readygo;
  logic                 WB_signal_valid;
  logic [MEM2WB_W-1:0]  WB_signal;
  logic [MEM_FWD_W-1:0] MEM_fwd;

  modport master (
`ifdef MEM_SUBWORD_LD_EN
    output EXE_to_MEM_ld_op,
`endif
    output EXE_to_MEM_valid, MEM_signal, data_sram_rdata, WB_allowin,
    input  MEM_allowin, MEM_readygo, WB_signal_valid, WB_signal, MEM_fwd
  );

  modport slave (
`ifdef MEM_SUBWORD_LD_EN
    input  EXE_to_MEM_ld_op,
`endif
    input  EXE_to_MEM_valid, MEM_signal, data_sram_rdata, WB_allowin,
    output MEM_allowin, MEM_readygo, WB_signal_valid, WB_signal, MEM_fwd
  );

endinterface

// File: rtl/ld_align.sv
// Sub-word load alignment: picks the byte/halfword lane and sign/zero-extends.
// Latency: combinational.
// Backpressure: none.
// Ports: ld_op (3b, 5..7 behave as word), addr (low 2 address bits), word (raw SRAM word), ld_data.
module ld_align
  import pipe_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[7:0];
    case (addr)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
  end

  // Halfword lane is chosen by addr[1] only; addr[0] is ignored for halfwords.
  assign half_lane = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld_data = word;
    case (ld_op)
      LD_B:    ld_data = {{24{byte_lane[7]}}, byte_lane};
      LD_BU:   ld_data = {24'd0, byte_lane};
      LD_H:    ld_data = {{16{half_lane[15]}}, half_lane};
      LD_HU:   ld_data = {16'd0, half_lane};
      default: ld_data = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers the EXE payload, completes SRAM load data, drives WB payload + forwarding.
// Latency: 1 cycle EXE->MEM register; final_result combinational from it and data_sram_rdata.
// Backpressure: never stalls itself (MEM_readygo=1); MEM_allowin follows WB_allowin while occupied.
// Ports: clk, reset (async active-low), bus (mem_stage_if.slave).
// Optional MEM_SUBWORD_LD_EN: adds EXE_to_MEM_ld_op and byte/halfword load alignment via ld_align.
module mem_stage
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  logic        mem_valid;
  exe2mem_t    pay;
  logic [31:0] rdata_hold;
  logic        hold_valid;
  logic        readygo;
  logic        allowin;
  logic        capture;
  logic [31:0] ld_word;
  logic [31:0] ld_data;
  logic [31:0] final_result;
  mem2wb_t     wb;
  mem_fwd_t    fwd;

  assign readygo = 1'b1;
  assign allowin = !mem_valid || (readygo && bus.WB_allowin);

  // The SRAM only presents a load's data during the entry's first MEM cycle; EXE may
  // issue new reads while WB is stalled, so snapshot it once and keep it until hand-off.
  assign capture = mem_valid && pay.res_from_mem && !bus.WB_allowin && !hold_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid  <= 1'b0;
      pay        <= '0;
      hold_valid <= 1'b0;
      rdata_hold <= '0;
    end else begin
      if (allowin) begin
        mem_valid <= bus.EXE_to_MEM_valid;
        if (bus.EXE_to_MEM_valid) begin
          pay <= exe2mem_t'(bus.MEM_signal);
        end
      end
      // Clear and capture cannot both be true (capture needs !WB_allowin with a
      // valid entry, i.e. allowin low); clear is listed first regardless.
      if (allowin) begin
        hold_valid <= 1'b0;
      end else if (capture) begin
        hold_valid <= 1'b1;
        rdata_hold <= bus.data_sram_rdata;
      end
    end
  end

  assign ld_word = hold_valid ? rdata_hold : bus.data_sram_rdata;

`ifdef MEM_SUBWORD_LD_EN
  logic [2:0] ld_op_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_op_q <= LD_W;
    end else if (allowin && bus.EXE_to_MEM_valid) begin
      ld_op_q <= bus.EXE_to_MEM_ld_op;
    end
  end

  ld_align u_ld_align (
    .ld_op   (ld_op_q),
    .addr    (pay.alu_result[1:0]),
    .word    (ld_word),
    .ld_data (ld_data)
  );
`else
  assign ld_data = ld_word;
`endif

  assign final_result = pay.res_from_mem ? ld_data : pay.alu_result;

  always_comb begin
    wb              = '0;
    wb.pc           = pay.pc;
    wb.rf_we        = pay.rf_we;
    wb.rf_waddr     = pay.rf_waddr;
    wb.final_result = final_result;
  end

  // r0 writes still travel to WB (which drops them) but must never be forwarded.
  always_comb begin
    fwd              = '0;
    fwd.fwd_we       = mem_valid && pay.rf_we && (pay.rf_waddr != 5'd0);
    fwd.rf_waddr     = pay.rf_waddr;
    fwd.final_result = final_result;
  end

  assign bus.MEM_allowin     = allowin;
  assign bus.MEM_readygo     = readygo;
  assign bus.WB_signal_valid = mem_valid;
  assign bus.WB_signal       = wb;
  assign bus.MEM_fwd         = fwd;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases then random traffic against a reference model.
// Latency: n/a.
// Backpressure: WB_allowin randomised to exercise stalls.
module tb_mem_stage;
  import pipe_pkg::*;

`ifdef MEM_SUBWORD_LD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Currently applied inputs.
  bit          cur_v;
  exe2mem_t    cur_s;
  bit [2:0]    cur_op;
  bit [31:0]   cur_rd;
  bit          cur_wa;

  // Reference model: what instruction occupies MEM, and the word the SRAM
  // returned during that instruction's first MEM cycle.
  bit          m_valid;
  exe2mem_t    m_pay;
  bit [2:0]    m_op;
  bit [31:0]   m_word;
  bit          m_first;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exe2mem_t mk(input bit [31:0] pc, input bit rfm, input bit we,
                                  input bit [4:0] wa, input bit [31:0] alu);
    exe2mem_t s;
    s.pc = pc; s.res_from_mem = rfm; s.rf_we = we; s.rf_waddr = wa; s.alu_result = alu;
    return s;
  endfunction

  function automatic bit [31:0] ref_ld(input bit [2:0] op, input bit [1:0] a, input bit [31:0] w);
    bit [31:0] b;
    bit [31:0] h;
    if (!SUBWORD) return w;
    b = (w >> (8 * int'(a))) & 32'h0000_00ff;
    h = (w >> (16 * int'(a[1]))) & 32'h0000_ffff;
    case (op)
      3'd1:    return (b >= 32'h80) ? (b - 32'h100) : b;
      3'd3:    return b;
      3'd2:    return (h >= 32'h8000) ? (h - 32'h1_0000) : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit [31:0] exp_final();
    bit [31:0] w;
    w = m_first ? cur_rd : m_word;
    return m_pay.res_from_mem ? ref_ld(m_op, m_pay.alu_result[1:0], w) : m_pay.alu_result;
  endfunction

  task automatic set_in(input bit v, input exe2mem_t s, input bit [2:0] op,
                        input bit [31:0] rd, input bit wa);
    cur_v = v; cur_s = s; cur_op = op; cur_rd = rd; cur_wa = wa;
    bus.EXE_to_MEM_valid = v;
    bus.MEM_signal       = s;
`ifdef MEM_SUBWORD_LD_EN
    bus.EXE_to_MEM_ld_op = op;
`endif
    bus.data_sram_rdata  = rd;
    bus.WB_allowin       = wa;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_pay = '0; m_op = 3'd0; m_word = '0; m_first = 1'b0;
  endtask

  task automatic check_model();
    bit [31:0] f;
    chk("readygo", 72'(bus.MEM_readygo), 72'(1'b1));
    chk("allowin", 72'(bus.MEM_allowin), 72'(!m_valid || cur_wa));
    chk("wb_vld", 72'(bus.WB_signal_valid), 72'(m_valid));
    if (m_valid) begin
      f = exp_final();
      chk("wb_sig", 72'(bus.WB_signal), 72'({m_pay.pc, m_pay.rf_we, m_pay.rf_waddr, f}));
      chk("fwd", 72'(bus.MEM_fwd),
          72'({m_pay.rf_we && (m_pay.rf_waddr != 5'd0), m_pay.rf_waddr, f}));
    end else begin
      chk("fwd_we_idle", 72'(bus.MEM_fwd[37]), 72'(1'b0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_valid && m_first) m_word = cur_rd;
    m_first = 1'b0;
    if (!m_valid || cur_wa) begin
      m_valid = cur_v;
      if (cur_v) begin
        m_pay = cur_s; m_op = cur_op; m_first = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    exe2mem_t s;
    model_reset();
    set_in(1'b0, '0, 3'd0, 32'h0, 1'b1);

    // Reset state.
    #3;
    chk("rst_wb_vld", 72'(bus.WB_signal_valid), 72'(1'b0));
    chk("rst_wb_sig", 72'(bus.WB_signal), 72'(0));
    chk("rst_fwd", 72'(bus.MEM_fwd), 72'(0));
    chk("rst_allowin", 72'(bus.MEM_allowin), 72'(1'b1));
    @(posedge clk); #1;
    reset = 1'b1;

    // ALU op to r5.
    set_in(1'b1, mk(32'h1c00_0010, 1'b0, 1'b1, 5'd5, 32'h0000_0abc), 3'd0, $urandom, 1'b1);
    #4; check_model(); tick();
    set_in(1'b0, '0, 3'd0, $urandom, 1'b1);
    #4; check_model();
    chk("alu_wb", 72'(bus.WB_signal), 72'({32'h1c00_0010, 1'b1, 5'd5, 32'h0000_0abc}));
    chk("alu_fwd", 72'(bus.MEM_fwd), 72'({1'b1, 5'd5, 32'h0000_0abc}));
    tick();

    // Bubble: previous cycle delivered nothing.
    #4; check_model();
    chk("bubble", 72'(bus.WB_signal_valid), 72'(1'b0));
    tick();

    // Stalled load to r7.
    set_in(1'b1, mk(32'h1c00_0020, 1'b1, 1'b1, 5'd7, 32'h0000_0100), 3'd0, $urandom, 1'b1);
    #4; check_model(); tick();
    set_in(1'b1, mk(32'h1c00_0024, 1'b0, 1'b1, 5'd8, 32'h1111), 3'd0, 32'h1234_5678, 1'b0);
    #4; check_model();
    chk("stall_res0", 72'(bus.WB_signal[31:0]), 72'(32'h1234_5678));
    chk("stall_allow0", 72'(bus.MEM_allowin), 72'(1'b0));
    tick();
    for (int i = 1; i < 3; i++) begin
      set_in(1'b1, cur_s, 3'd0, 32'hdead_beef, 1'b0);
      #4; check_model();
      chk("stall_res", 72'(bus.WB_signal[31:0]), 72'(32'h1234_5678));
      chk("stall_allow", 72'(bus.MEM_allowin), 72'(1'b0));
      tick();
    end
    set_in(1'b1, cur_s, 3'd0, 32'hdead_beef, 1'b1);
    #4; check_model();
    chk("stall_release", 72'(bus.WB_signal[31:0]), 72'(32'h1234_5678));
    tick();

    // r0 write: visible to WB, never forwarded.
    set_in(1'b1, mk(32'h1c00_0030, 1'b0, 1'b1, 5'd0, 32'h55), 3'd0, $urandom, 1'b1);
    #4; check_model(); tick();
    set_in(1'b0, '0, 3'd0, $urandom, 1'b1);
    #4; check_model();
    chk("r0_fwd_we", 72'(bus.MEM_fwd[37]), 72'(1'b0));
    chk("r0_wb_we", 72'(bus.WB_signal[37]), 72'(1'b1));
    tick();

`ifdef MEM_SUBWORD_LD_EN
    begin
      bit [2:0]  ops  [4] = '{3'd1, 3'd3, 3'd2, 3'd4};
      bit [1:0]  adrs [4] = '{2'b11, 2'b10, 2'b00, 2'b10};
      bit [31:0] exps [4] = '{32'hffff_ff80, 32'h0000_00ff, 32'h0000_7f01, 32'h0000_80ff};
      for (int k = 0; k < 4; k++) begin
        set_in(1'b1, mk(32'h1c00_0040, 1'b1, 1'b1, 5'd3, {30'h400, adrs[k]}), ops[k], $urandom, 1'b1);
        #4; check_model(); tick();
        set_in(1'b0, '0, 3'd0, 32'h80ff_7f01, 1'b1);
        #4; check_model();
        chk("subword", 72'(bus.WB_signal[31:0]), 72'(exps[k]));
        tick();
      end
    end
`endif

    // Reset in the middle of a stalled load.
    set_in(1'b1, mk(32'h1c00_0050, 1'b1, 1'b1, 5'd9, 32'h200), 3'd0, $urandom, 1'b1);
    #4; check_model(); tick();
    set_in(1'b1, mk(32'h1c00_0054, 1'b0, 1'b1, 5'd10, 32'h2), 3'd0, 32'haaaa_5555, 1'b0);
    #4; check_model(); tick();
    set_in(1'b1, cur_s, 3'd0, 32'h0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_wb_vld", 72'(bus.WB_signal_valid), 72'(1'b0));
    chk("mid_rst_allowin", 72'(bus.MEM_allowin), 72'(1'b1));
    chk("mid_rst_fwd", 72'(bus.MEM_fwd), 72'(0));
    model_reset();
    set_in(1'b0, '0, 3'd0, 32'h0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      s = mk($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom);
      set_in($urandom_range(0, 3) != 0, s, 3'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 9) < 6);
      #4; check_model();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage in-order pipeline. Sits directly downstream of `exe_stage` and upstream of `wb_stage`. Registers the 71-bit EXE→MEM payload and completes load data from the synchronous data SRAM, whose read was issued in EXE. Produces the WB payload and a forwarding bus. Holds load data internally when WB stalls, so that re-issued EXE requests cannot corrupt it.

## Interface
- No parameters.
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-low reset
- `EXE_to_MEM_valid`  in  1  EXE payload valid (driven by `MEM_signal_valid`)
- `MEM_signal`  in  71  {pc[31:0], res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0]}
- `EXE_to_MEM_ld_op`  in  3  load type, present only with `MEM_SUBWORD_LD_EN`: 0 W, 1 B, 2 H, 3 BU, 4 HU
- `data_sram_rdata`  in  32  SRAM read data, valid the cycle after the EXE request
- `WB_allowin`  in  1  WB can accept
- `MEM_allowin`  out  1  MEM can accept from EXE
- `MEM_readygo`  out  1  constant 1
- `WB_signal_valid`  out  1  WB payload valid
- `WB_signal`  out  70  {pc[31:0], rf_we, rf_waddr[4:0], final_result[31:0]}
- `MEM_fwd`  out  38  {fwd_we, rf_waddr[4:0], final_result[31:0]}

## Operation
- Internal state:
  - `MEM_valid`
  - payload register, 71 bits (74 with the macro)
  - `rdata_hold[31:0]` and `hold_valid`
- Handshake:
  - `MEM_allowin = !MEM_valid || (MEM_readygo && WB_allowin)`.
  - On each clock edge where `MEM_allowin` is high: `MEM_valid <= EXE_to_MEM_valid`.
  - If `EXE_to_MEM_valid` is also high, the payload register loads `MEM_signal`.
  - If `EXE_to_MEM_valid` is low, the payload register keeps its old value.
- Hold:
  - Capture condition: `MEM_valid && res_from_mem && !WB_allowin && !hold_valid`.
  - When it is true: `rdata_hold <= data_sram_rdata` and `hold_valid <= 1`.
  - `hold_valid` clears on any edge where `MEM_allowin` is high.
  - Clear wins over capture; the two are mutually exclusive by construction.
- Load data:
  - `ld_word = hold_valid ? rdata_hold : data_sram_rdata`.
- `final_result = res_from_mem ? ld_data : alu_result`.
- `WB_signal_valid = MEM_valid`.
- `fwd_we = MEM_valid && rf_we && (rf_waddr != 0)`.
- Writes to r0 are never forwarded. `WB_signal` still carries the r0 write; WB discards it.

## Timing
- Reset (asynchronous assert, synchronous-release assumed at top):
  - `MEM_valid = 0`, payload = 0, `hold_valid = 0`, `rdata_hold = 0`.
  - Outputs: `WB_signal_valid = 0`, `WB_signal = 0`, `MEM_fwd = 0`, `MEM_allowin = 1`.
- Latency: one cycle EXE→MEM register. `final_result` is combinational from that register plus `data_sram_rdata`. No stall is generated; `MEM_readygo` is always 1.
- Load data path:
  - A load with `WB_allowin = 1` uses live `data_sram_rdata` in its first MEM cycle.
  - A stalled load uses `rdata_hold` from its second MEM cycle onward.
- Back-to-back: with `WB_allowin` held high, one instruction passes per cycle and `hold_valid` is never set.
- Simultaneous events: at an edge where MEM hands off to WB and EXE delivers a new entry, the new payload loads and `hold_valid` clears in the same edge.
- Reset mid-stall: the held entry is dropped and `hold_valid` clears.

## Configuration
- `MEM_SUBWORD_LD_EN` defined:
  - Port `EXE_to_MEM_ld_op` exists and is registered with the payload.
  - Byte lane select = `alu_result[1:0]`. Halfword lane select = `alu_result[1]`.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - ld_op values 5–7 are treated as W.
- `MEM_SUBWORD_LD_EN` not defined:
  - Port absent; `ld_data = ld_word`.
  - Alignment bits are ignored.

## Structure
- Shared package `pipe_pkg`:
  - widths `EXE2MEM_W = 71`, `MEM2WB_W = 70`, `MEM_FWD_W = 38`
  - `ld_op` encodings `LD_W`, `LD_B`, `LD_H`, `LD_BU`, `LD_HU`
  - Fields are packed/unpacked in the same bit order as the payload definitions in Interface.
- Sub-module `ld_align` (combinational: `ld_op`, `addr[1:0]`, `word` → `ld_data`), instantiated only under the macro.

## Test plan
- Reset asserted mid-run with `MEM_valid = 1` → `WB_signal_valid = 0`, `MEM_allowin = 1`, `MEM_fwd = 0` immediately, with no clock edge required.
- ALU op:
  - Stimulus: `MEM_signal = {pc 0x1c000010, 0, 1, r5, 0x00000abc}`, `WB_allowin = 1`.
  - Response: the next cycle, `WB_signal = {0x1c000010, 1, 5, 0x00000abc}` and `MEM_fwd = {1, 5, 0x00000abc}`.
- Stalled load:
  - Stimulus: a load to r7; `rdata = 0x12345678` in its first MEM cycle, then `WB_allowin = 0` for 3 cycles while rdata changes to 0xdeadbeef.
  - Response: `final_result` stays 0x12345678 throughout the stall, and `MEM_allowin = 0` for those cycles.
- r0 write with `rf_we = 1`, `rf_waddr = 0` → `MEM_fwd[37] = 0`; `WB_signal.rf_we = 1`.
- Bubble → `EXE_to_MEM_valid = 0` with `WB_allowin = 1` → `WB_signal_valid = 0` next cycle.
- With `MEM_SUBWORD_LD_EN` defined:
  - Stimulus: rdata `0x80ff7f01`.
  - B @ addr low bits 2'b11 → `0xffffff80`.
  - BU @ addr low bits 2'b10 → `0x000000ff`.
  - H @ addr bit1 = 0 → `0x00007f01`.
  - HU @ addr bit1 = 1 → `0x000080ff`.
